// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side consumer.
// The reader FSM state type lives here so debug/checker code can decode it.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    localparam int NUM_SLOTS = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        RESP  = 3'd3,
        FIN   = 3'd4
    } reader_state_t;

endpackage

// File: rtl/instr_exec_unit.sv
// Combinational opcode decoder/ALU: maps one instruction to a 64-bit signed
// result plus a divide-by-zero flag.
module instr_exec_unit
    import instr_register_pkg::*;
(
    input  instruction_t iw,
    output result_t      result,
    output logic         err_div0
);

    result_t a;
    result_t b;

    // Widening before DIV keeps -2^31 / -1 representable (+2^31).
    assign a = {{32{iw.op_a[31]}}, iw.op_a};
    assign b = {{32{iw.op_b[31]}}, iw.op_b};

    always_comb begin
        result   = '0;
        err_div0 = 1'b0;
        case (iw.opc)
            ZERO:  result = '0;
            PASSA: result = a;
            PASSB: result = b;
            ADD:   result = a + b;
            SUB:   result = a - b;
            MULT:  result = a * b;
            DIV: begin
                if (b == '0) err_div0 = 1'b1;
                else         result   = a / b;
            end
            MOD: begin
                if (b == '0) err_div0 = 1'b1;
                else         result   = a % b;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_reader_alu.sv
// Walks a range of instruction-register slots, executes each instruction and
// streams one result per slot over a valid/ready handshake.
module instr_reader_alu
    import instr_register_pkg::*;
#(
    parameter int RESULT_W = 64,
    parameter int AUTO_ACK = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  address_t            first_addr,
    input  logic [5:0]          count,
    output address_t            read_pointer,
    input  instruction_t        instruction_word,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RESULT_W-1:0] result,
    output opcode_t             res_opcode,
    output address_t            res_addr,
    output logic                err_div0,
    output logic                busy,
    output logic                done,
    output reader_state_t       dbg_state
);

    reader_state_t       state;
    reader_state_t       next_state;
    address_t            ptr;
    logic [5:0]          remaining;
    instruction_t        iw_q;
    logic [RESULT_W-1:0] result_q;
    opcode_t             opc_q;
    address_t            addr_q;
    logic                err_q;
    result_t             exec_result;
    logic                exec_err;
    logic                handshake;

    instr_exec_unit u_exec (
        .iw       (iw_q),
        .result   (exec_result),
        .err_div0 (exec_err)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Handshake: a result transfers on a rising edge where res_valid && res_ready
    // (or on the first RESP cycle when AUTO_ACK is set); result, res_opcode,
    // res_addr and err_div0 are held stable from res_valid rising until then.
    always_comb begin
        next_state = state;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (count == 6'd0) ? FIN : FETCH;
            end
            FETCH: next_state = EXEC;
            EXEC:  next_state = RESP;
            RESP: begin
                handshake = (AUTO_ACK != 0) || res_ready;
                if (handshake) next_state = (remaining > 6'd1) ? FETCH : FIN;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            iw_q      <= '0;
            result_q  <= '0;
            opc_q     <= ZERO;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && start && count != 6'd0) begin
                ptr       <= first_addr;
                remaining <= count;
            end
            if (state == FETCH) iw_q <= instruction_word;
            if (state == EXEC) begin
                result_q <= RESULT_W'(exec_result);
                opc_q    <= iw_q.opc;
                addr_q   <= ptr;
                err_q    <= exec_err;
            end
            // The pointer only moves when another fetch follows, so it holds
            // the last slot read once the walk finishes.
            if (handshake) begin
                remaining <= remaining - 6'd1;
                if (remaining > 6'd1) ptr <= ptr + 5'd1;
            end
        end
    end

    assign read_pointer = ptr;
    assign res_valid    = (state == RESP);
    assign busy         = (state != IDLE);
    assign done         = (state == FIN);
    assign result       = result_q;
    assign res_opcode   = opc_q;
    assign res_addr     = addr_q;
    assign err_div0     = err_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_instr_reader_alu.sv
// Self-checking bench for instr_reader_alu: constant vector table, directed
// multi-cycle sequences and randomized walks against an arithmetic model.
module tb_instr_reader_alu;
    import instr_register_pkg::*;

    localparam int RW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    address_t      first_addr = '0;
    logic [5:0]    count = '0;
    address_t      read_pointer;
    instruction_t  instruction_word;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] result;
    opcode_t       res_opcode;
    address_t      res_addr;
    logic          err_div0;
    logic          busy;
    logic          done;
    reader_state_t dbg_state;

    instruction_t mem [NUM_SLOTS];
    int checks = 0;
    int failures = 0;

    logic [63:0] exp_res_q[$];
    logic [0:0]  exp_err_q[$];
    logic [4:0]  exp_addr_q[$];
    logic [3:0]  exp_opc_q[$];

    typedef struct {
        opcode_t opc;
        int      a;
        int      b;
        longint  exp_res;
        logic    exp_err;
    } vec_t;
    vec_t vecs[14];

    instr_reader_alu #(.RESULT_W(RW), .AUTO_ACK(0)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .res_opcode       (res_opcode),
        .res_addr         (res_addr),
        .err_div0         (err_div0),
        .busy             (busy),
        .done             (done),
        .dbg_state        (dbg_state)
    );

    // clock / combinational instruction register model
    always #5 clk = ~clk;
    assign instruction_word = mem[read_pointer];

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    // reference model: spec arithmetic on 64-bit signed integers
    function automatic logic [63:0] model_res(input instruction_t iw, output logic e);
        longint a;
        longint b;
        longint r;
        a = longint'(iw.op_a);
        b = longint'(iw.op_b);
        r = 0;
        e = 1'b0;
        case (iw.opc)
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
            DIV:   if (b == 0) e = 1'b1; else r = a / b;
            MOD:   if (b == 0) e = 1'b1; else r = a % b;
            default: r = 0;
        endcase
        return 64'(r);
    endfunction

    function automatic instruction_t rand_instr();
        instruction_t iw;
        iw.opc = opcode_t'(4'($urandom_range(0, 9)));
        case ($urandom_range(0, 3))
            0: begin iw.op_a = operand_t'($urandom); iw.op_b = operand_t'($urandom); end
            1: begin iw.op_a = operand_t'(int'($urandom_range(0, 40)) - 20);
                     iw.op_b = operand_t'(int'($urandom_range(0, 40)) - 20); end
            2: begin iw.op_a = operand_t'($urandom); iw.op_b = '0; end
            default: begin iw.op_a = operand_t'(int'($urandom_range(0, 200)) - 100);
                           iw.op_b = operand_t'($urandom); end
        endcase
        return iw;
    endfunction

    task automatic pulse_start(input address_t fa, input logic [5:0] c);
        start = 1'b1;
        first_addr = fa;
        count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        check_bit(name, res_valid, 1'b1);
    endtask

    task automatic get_one(input address_t fa, output logic [63:0] r, output logic e,
                           output address_t a);
        res_ready = 1'b1;
        pulse_start(fa, 6'd1);
        wait_valid("one_valid");
        r = result;
        e = err_div0;
        a = res_addr;
        tick();
        tick();
    endtask

    task automatic run_walk(input address_t fa, input logic [5:0] cnt, input bit rand_ready);
        int got;
        int cyc;
        bit stalled;
        logic [63:0] h_res;
        address_t h_addr;
        address_t s;
        logic e;
        for (int i = 0; i < int'(cnt); i++) begin
            s = address_t'((int'(fa) + i) % NUM_SLOTS);
            exp_res_q.push_back(model_res(mem[s], e));
            exp_err_q.push_back(e);
            exp_addr_q.push_back(s);
            exp_opc_q.push_back(mem[s].opc);
        end
        pulse_start(fa, cnt);
        got = 0;
        cyc = 0;
        stalled = 0;
        while (got < int'(cnt) && cyc < 2000) begin
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check_bit("stall_valid", res_valid, 1'b1);
                check("stall_result", result, h_res);
                check("stall_addr", 64'(res_addr), 64'(h_addr));
            end
            stalled = 0;
            if (res_valid) begin
                if (res_ready) begin
                    check("walk_result", result, exp_res_q.pop_front());
                    check("walk_err", 64'(err_div0), 64'(exp_err_q.pop_front()));
                    check("walk_addr", 64'(res_addr), 64'(exp_addr_q.pop_front()));
                    check("walk_opc", 64'(res_opcode), 64'(exp_opc_q.pop_front()));
                    got++;
                end else begin
                    stalled = 1;
                    h_res = result;
                    h_addr = res_addr;
                end
            end
            tick();
            cyc++;
        end
        check("walk_count", 64'(got), 64'(cnt));
        exp_res_q.delete();
        exp_err_q.delete();
        exp_addr_q.delete();
        exp_opc_q.delete();
        res_ready = 1'b1;
        check_bit("walk_done", done, 1'b1);
        tick();
        check_bit("walk_done_drop", done, 1'b0);
        check_bit("walk_idle", busy, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        logic e;
        address_t a;

        vecs[0]  = '{ADD,   5, 7, 12, 1'b0};
        vecs[1]  = '{SUB,   3, 10, -7, 1'b0};
        vecs[2]  = '{MULT, -4, 100000, -400000, 1'b0};
        vecs[3]  = '{DIV,  -7, 2, -3, 1'b0};
        vecs[4]  = '{MOD,   9, 0, 0, 1'b1};
        vecs[5]  = '{MOD,  -9, 4, -1, 1'b0};
        vecs[6]  = '{DIV,   5, 0, 0, 1'b1};
        vecs[7]  = '{ZERO, 123, 4, 0, 1'b0};
        vecs[8]  = '{PASSA, -42, 9, -42, 1'b0};
        vecs[9]  = '{PASSB, 1, -77, -77, 1'b0};
        vecs[10] = '{MULT, 2147483647, 2147483647, 64'sd4611686014132420609, 1'b0};
        vecs[11] = '{DIV, 32'h8000_0000, -1, 64'sd2147483648, 1'b0};
        vecs[12] = '{MOD,   7, -3, 1, 1'b0};
        vecs[13] = '{opcode_t'(4'hF), 5, 6, 0, 1'b0};
        for (int s = 0; s < NUM_SLOTS; s++) mem[s] = '0;

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_result", result, 64'd0);
        check_bit("rst_valid", res_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err_div0, 1'b0);
        check("rst_ptr", 64'(read_pointer), 64'd0);
        check("rst_addr", 64'(res_addr), 64'd0);
        check("rst_opc", 64'(res_opcode), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b0;
        tick();

        // latency of a single ADD from slot 0
        mem[0] = '{opc: ADD, op_a: 32'sd5, op_b: 32'sd7};
        res_ready = 1'b1;
        pulse_start(5'd0, 6'd1);
        check_bit("lat_fetch_valid", res_valid, 1'b0);
        check("lat_fetch_state", 64'(dbg_state), 64'(FETCH));
        check_bit("lat_fetch_busy", busy, 1'b1);
        tick();
        check_bit("lat_exec_valid", res_valid, 1'b0);
        tick();
        check_bit("lat_resp_valid", res_valid, 1'b1);
        check("lat_result", result, 64'd12);
        check("lat_addr", 64'(res_addr), 64'd0);
        tick();
        check_bit("lat_done", done, 1'b1);
        check_bit("lat_valid_drop", res_valid, 1'b0);
        tick();
        check_bit("lat_done_drop", done, 1'b0);
        check_bit("lat_busy_drop", busy, 1'b0);

        // opcode table, one slot per vector
        for (int i = 0; i < 14; i++) begin
            mem[i] = '{opc: vecs[i].opc, op_a: operand_t'(vecs[i].a), op_b: operand_t'(vecs[i].b)};
            get_one(address_t'(i), r, e, a);
            check($sformatf("vec%0d_result", i), r, 64'(vecs[i].exp_res));
            check_bit($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("vec%0d_addr", i), 64'(a), 64'(i));
        end

        // wrap across slot 31 -> 0
        mem[30] = '{opc: SUB,  op_a: 32'sd3,  op_b: 32'sd10};
        mem[31] = '{opc: MULT, op_a: -32'sd4, op_b: 32'sd100000};
        mem[0]  = '{opc: DIV,  op_a: -32'sd7, op_b: 32'sd2};
        run_walk(5'd30, 6'd3, 1'b0);

        // consumer stalls for 10 cycles on the first result
        mem[10] = '{opc: ADD, op_a: 32'sd1, op_b: 32'sd2};
        mem[11] = '{opc: SUB, op_a: 32'sd1, op_b: 32'sd2};
        res_ready = 1'b0;
        pulse_start(5'd10, 6'd2);
        wait_valid("stall_first_valid");
        for (int i = 0; i < 10; i++) begin
            check_bit("stall10_valid", res_valid, 1'b1);
            check("stall10_result", result, 64'd3);
            check("stall10_ptr", 64'(read_pointer), 64'd10);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_bit("stall_after_hs_valid", res_valid, 1'b0);
        check("stall_after_hs_ptr", 64'(read_pointer), 64'd11);
        wait_valid("stall_second_valid");
        check("stall_second_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("stall_second_addr", 64'(res_addr), 64'd11);
        res_ready = 1'b1;
        tick();
        check_bit("stall_done", done, 1'b1);
        tick();

        // count == 0, plus a start while busy in FIN
        pulse_start(5'd3, 6'd0);
        check_bit("cnt0_done", done, 1'b1);
        check_bit("cnt0_busy", busy, 1'b1);
        check_bit("cnt0_valid", res_valid, 1'b0);
        start = 1'b1;
        count = 6'd1;
        tick();
        start = 1'b0;
        check_bit("cnt0_done_drop", done, 1'b0);
        check_bit("cnt0_idle", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_bit("cnt0_no_valid", res_valid, 1'b0);
            tick();
        end

        // start while mid-walk is ignored
        mem[4] = '{opc: PASSA, op_a: 32'sd44, op_b: 32'sd0};
        pulse_start(5'd4, 6'd1);
        start = 1'b1;
        first_addr = 5'd20;
        count = 6'd5;
        tick();
        start = 1'b0;
        wait_valid("busy_start_valid");
        check("busy_start_result", result, 64'd44);
        check("busy_start_addr", 64'(res_addr), 64'd4);
        tick();
        tick();
        check_bit("busy_start_idle", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_bit("busy_start_no_valid", res_valid, 1'b0);
            tick();
        end
        check("busy_start_ptr_hold", 64'(read_pointer), 64'd4);

        // reset while a result is stalled in RESP
        mem[8] = '{opc: ADD,  op_a: 32'sd100, op_b: 32'sd1};
        mem[2] = '{opc: MULT, op_a: 32'sd6,   op_b: 32'sd7};
        res_ready = 1'b0;
        pulse_start(5'd8, 6'd1);
        wait_valid("rstmid_valid");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit("rstmid_valid_clr", res_valid, 1'b0);
        check("rstmid_result", result, 64'd0);
        check("rstmid_addr", 64'(res_addr), 64'd0);
        check("rstmid_ptr", 64'(read_pointer), 64'd0);
        check_bit("rstmid_busy", busy, 1'b0);
        check_bit("rstmid_done", done, 1'b0);
        check("rstmid_state", 64'(dbg_state), 64'(IDLE));
        tick();
        get_one(5'd2, r, e, a);
        check("rstmid_next_result", r, 64'd42);
        check("rstmid_next_addr", 64'(a), 64'd2);

        // randomized walks against the model
        for (int w = 0; w < 25; w++) begin
            for (int s = 0; s < NUM_SLOTS; s++) mem[s] = rand_instr();
            run_walk((w == 0) ? 5'd17 : address_t'($urandom_range(0, 31)),
                     (w == 0) ? 6'd32 : 6'($urandom_range(1, 32)), (w % 2) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
